// File: rtl/checker_sumador.sv
// rtl/checker_sumador.sv - scoreboard checker for a pipelined 4-bit adder
// Optional build macro CHECKER_STOP_ON_ERR_EN: first mismatch halts checking until reset.
module checker_sumador #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             valid_in,
  input  logic [3:0]       idx,
  input  logic [3:0]       dataA,
  input  logic [3:0]       dataB,
  input  logic [3:0]       idx_dd,
  input  logic [3:0]       sum30_dd,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       last_err_idx,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state_q;
  logic             vld_q [LATENCY];
  logic [3:0]       tag_q [LATENCY];
  logic [3:0]       sum_q [LATENCY];
  logic             err_q;
  logic             err_sticky_q;
  logic [CNT_W-1:0] ok_count_q;
  logic [CNT_W-1:0] ok_count_d;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] err_count_d;
  logic [3:0]       last_err_idx_q;
  logic [3:0]       last_err_idx_d;
  logic             busy_q;
  logic             busy_d;
  logic [3:0]       sum_in;
  logic             chk;
  logic             hit;
  logic             miss;

  // The oldest pipeline slot lines up with the adder's response this cycle.
  always_comb begin
    sum_in = dataA + dataB;
    chk    = vld_q[LATENCY-1] && (state_q == RUN);
    hit    = (idx_dd == tag_q[LATENCY-1]) && (sum30_dd == sum_q[LATENCY-1]);
    miss   = chk && !hit;

    ok_count_d = ok_count_q;
    if (chk && hit && (ok_count_q != {CNT_W{1'b1}}))
      ok_count_d = ok_count_q + CNT_W'(1);

    err_count_d    = err_count_q;
    last_err_idx_d = last_err_idx_q;
    if (miss) begin
      last_err_idx_d = tag_q[LATENCY-1];
      if (err_count_q != {CNT_W{1'b1}})
        err_count_d = err_count_q + CNT_W'(1);
    end

    // Busy reflects what will be in flight after this edge, slot LATENCY-1 retiring now.
    busy_d = valid_in;
    for (int i = 0; i < LATENCY - 1; i++)
      busy_d = busy_d | vld_q[i];
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q        <= IDLE;
      err_q          <= 1'b0;
      err_sticky_q   <= 1'b0;
      ok_count_q     <= '0;
      err_count_q    <= '0;
      last_err_idx_q <= 4'd0;
      busy_q         <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= 4'd0;
        sum_q[i] <= 4'd0;
      end
    end else begin
      vld_q[0] <= valid_in;
      tag_q[0] <= idx;
      sum_q[0] <= sum_in;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
        sum_q[i] <= sum_q[i-1];
      end

      err_q          <= miss;
      err_sticky_q   <= err_sticky_q | miss;
      ok_count_q     <= ok_count_d;
      err_count_q    <= err_count_d;
      last_err_idx_q <= last_err_idx_d;
      busy_q         <= busy_d;

      case (state_q)
        IDLE: if (valid_in) state_q <= RUN;
        RUN: begin
`ifdef CHECKER_STOP_ON_ERR_EN
          if (miss) state_q <= HALT;
`else
          state_q <= RUN;
`endif
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign err          = err_q;
  assign err_sticky   = err_sticky_q;
  assign ok_count     = ok_count_q;
  assign err_count    = err_count_q;
  assign last_err_idx = last_err_idx_q;
  assign busy         = busy_q;
  assign state        = state_q;

endmodule

// File: doc/checker_sumador.md
CHECKER_SUMADOR -- requirements
Module: checker_sumador

Interface
REQ-001 The module SHALL have parameter LATENCY, default 2, meaning the clock edges between stimulus sampling and response sampling (legal range 1..4).
REQ-002 The module SHALL have parameter CNT_W, default 8, meaning the width of the match and error counters.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The module SHALL have port reset_L, input, 1, the reset, which is asynchronous and active-low.
REQ-005 The module SHALL have port valid_in, input, 1, which qualifies idx/dataA/dataB in the current cycle.
REQ-006 The module SHALL have ports idx, dataA and dataB, input, 4 each: the stimulus tag and the operands driven to the pipelined adder.
REQ-007 The module SHALL have ports idx_dd and sum30_dd, input, 4 each: the pipelined adder's delayed tag and sum.
REQ-008 The module SHALL have port err, output, 1, a one-cycle pulse flagging a mismatch.
REQ-009 The module SHALL have port err_sticky, output, 1, set on the first mismatch and held until reset.
REQ-010 The module SHALL have ports ok_count and err_count, output, CNT_W each: saturating counts of matches and mismatches.
REQ-011 The module SHALL have port last_err_idx, output, 4, holding the expected idx of the most recent mismatch.
REQ-012 The module SHALL have port busy, output, 1, high while any qualified stimulus is in flight.
REQ-013 The module SHALL have port state, output, 2, the FSM state encoding (IDLE=0, RUN=1, HALT=2).

Function
REQ-014 On each rising edge, the module SHALL push {valid_in, idx, (dataA+dataB) mod 16} into a LATENCY-deep internal shift register.
REQ-015 The expected sum SHALL be the 4-bit wrap-around of dataA+dataB, with the carry discarded (15+3 -> 2).
REQ-016 A check SHALL occur at edge T+LATENCY for stimulus sampled at edge T only if that entry's valid bit is 1 and state is RUN; entries with valid=0 are ignored.
REQ-017 A check SHALL be a match when idx_dd equals the expected idx and sum30_dd equals the expected sum; any difference SHALL be a single mismatch, even when idx and sum both differ.
REQ-018 On a match, ok_count SHALL increment by 1 at the checking edge, saturating at all-ones.
REQ-019 On a mismatch, the following SHALL happen at the checking edge: err=1 for exactly one cycle, err_sticky=1, err_count incremented (saturating at all-ones), and last_err_idx set to the expected idx.
REQ-020 The FSM SHALL transition IDLE->RUN on the first edge with valid_in=1; RUN persists; HALT is reachable only per REQ-026; no other transitions exist.
REQ-021 In IDLE, the shift register SHALL still accept pushes so that a stimulus sampled on the IDLE->RUN edge is checked LATENCY edges later.
REQ-022 busy SHALL be the OR of all in-flight valid bits, registered.
REQ-023 A stimulus and a response check occurring on the same edge SHALL both be processed independently (back-to-back throughput, one check per cycle).

Reset
REQ-024 While reset_L=0, regardless of clk, the module SHALL drive err=0, err_sticky=0, ok_count=0, err_count=0, last_err_idx=0, busy=0, state=IDLE, and clear all shift register entries, including valid bits.
REQ-025 An assertion of reset_L mid-stream SHALL discard in-flight stimuli, and no checks SHALL occur for them after release.

Configuration
REQ-026 With macro CHECKER_STOP_ON_ERR_EN defined, the first mismatch SHALL move the FSM RUN->HALT on the same edge; in HALT no further checks occur, and counters and last_err_idx freeze until reset. Without the macro, HALT is unreachable and checking continues after errors.

Verification
REQ-027 Match (LATENCY=2): valid_in=1, idx=3, A=5, B=9 at edge 0; idx_dd=3, sum30_dd=14 at edge 2 -> ok_count=1, err=0, state=RUN.
REQ-028 Wrap: A=15, B=3, idx=7; response sum30_dd=2, idx_dd=7 -> match; a response of sum30_dd=18&0xF mis-driven to 3 -> err pulse, last_err_idx=7.
REQ-029 Mismatch: idx=4, A=2, B=2, response sum30_dd=5 -> err=1 one cycle, err_sticky=1, err_count=1; with CHECKER_STOP_ON_ERR_EN, state=HALT and a following correct response leaves ok_count unchanged.
REQ-030 Saturation (CNT_W=2): 5 consecutive matching stimuli -> ok_count=3 and holds.
REQ-031 Reset mid-flight: valid stimulus at edge 0, reset_L low between edges 0 and 1 -> all outputs 0 immediately; after release with no new valid, no check fires at edge 2.
REQ-032 Gaps: valid_in pattern 1,0,1 with garbage idx_dd/sum30_dd on the gap slot -> exactly 2 checks, err_count=0.
